// File: rtl/ula_control_fsm.sv
// Multi-cycle control unit: captures an instruction on Run in T0, sequences T1..T3 datapath enables and the ULA opcode.
// Latency: Done one cycle after the Run edge for MV/MVI/MVNZ/illegal, three cycles for ALU ops.
// Backpressure: Run is sampled only in T0; it is ignored while an instruction is in flight.
module ula_control_fsm #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    input  logic              G_nz,
    output logic              IRin,
    output logic [NREG-1:0]   Rin,
    output logic [NREG-1:0]   Rout,
    output logic              Ain,
    output logic              Gin,
    output logic              Gout,
    output logic              DINout,
    output logic [3:0]        operacao,
    output logic              Done
);

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [3:0] OP_MV   = 4'b0000;
    localparam logic [3:0] OP_MVI  = 4'b0001;
    localparam logic [3:0] OP_MVNZ = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1010;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [DATA_W-1:0] ir;
    logic [3:0]        op;
    logic [2:0]        rx;
    logic [2:0]        ry;
    logic              is_alu;
    logic              unused_ir;

    assign op        = ir[15:12];
    assign rx        = ir[11:9];
    assign ry        = ir[8:6];
    assign unused_ir = ^ir[5:0];

    function automatic logic [NREG-1:0] sel(input logic [2:0] idx);
        sel      = '0;
        sel[idx] = 1'b1;
    endfunction

    always_comb begin
        case (op)
            OP_ADD, OP_SUB, OP_OR, OP_SLT, OP_SRL, OP_SLL: is_alu = 1'b1;
            default:                                       is_alu = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == T0 && Run)
                ir <= DIN;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            T0:      state_nxt = Run ? T1 : T0;
            T1:      state_nxt = is_alu ? T2 : T0;
            T2:      state_nxt = T3;
            default: state_nxt = T0;
        endcase
    end

    // Outputs are forced low while Reset is high so an aborted instruction emits nothing more.
    always_comb begin
        IRin     = 1'b0;
        Rin      = '0;
        Rout     = '0;
        Ain      = 1'b0;
        Gin      = 1'b0;
        Gout     = 1'b0;
        DINout   = 1'b0;
        operacao = 4'b0000;
        Done     = 1'b0;
        if (!Reset) begin
            case (state)
                T0: IRin = Run;
                T1: begin
                    case (op)
                        OP_MV: begin
                            Rout = sel(ry);
                            Rin  = sel(rx);
                            Done = 1'b1;
                        end
                        OP_MVI: begin
                            DINout = 1'b1;
                            Rin    = sel(rx);
                            Done   = 1'b1;
                        end
                        OP_MVNZ: begin
                            if (G_nz) begin
                                Rout = sel(ry);
                                Rin  = sel(rx);
                            end
                            Done = 1'b1;
                        end
                        default: begin
                            if (is_alu) begin
                                Rout = sel(rx);
                                Ain  = 1'b1;
                            end else begin
                                Done = 1'b1;
                            end
                        end
                    endcase
                end
                T2: begin
                    Rout     = sel(ry);
                    Gin      = 1'b1;
                    operacao = op;
                end
                default: begin
                    Gout = 1'b1;
                    Rin  = sel(rx);
                    Done = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_control_fsm.sv
// Directed bench for ula_control_fsm: per-scenario tasks compare the packed output vector each cycle.
module tb_ula_control_fsm;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Run   = 1'b0;
    logic [15:0] DIN   = 16'h0000;
    logic        G_nz  = 1'b0;
    logic        IRin;
    logic [7:0]  Rin;
    logic [7:0]  Rout;
    logic        Ain;
    logic        Gin;
    logic        Gout;
    logic        DINout;
    logic [3:0]  operacao;
    logic        Done;

    int total = 0;
    int bad   = 0;

    logic [25:0] obs;
    logic [25:0] exp_v;

    ula_control_fsm #(.DATA_W(16), .NREG(8)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN), .G_nz(G_nz),
        .IRin(IRin), .Rin(Rin), .Rout(Rout), .Ain(Ain), .Gin(Gin), .Gout(Gout),
        .DINout(DINout), .operacao(operacao), .Done(Done)
    );

    always #5 Clock = ~Clock;

    assign obs = {IRin, Rin, Rout, Ain, Gin, Gout, DINout, operacao, Done};

    // Field order: IRin, Rin, Rout, Ain, Gin, Gout, DINout, operacao, Done
    function automatic logic [25:0] ex(input logic irin, input logic [7:0] rin, input logic [7:0] rout,
                                       input logic ain, input logic gin, input logic gout,
                                       input logic dinout, input logic [3:0] op, input logic done);
        return {irin, rin, rout, ain, gin, gout, dinout, op, done};
    endfunction

    // Every cycle: Rin/Rout one-hot or zero, operacao nonzero only alongside Gin (T2).
    always @(negedge Clock) begin
        total++;
        if (!($onehot0(Rin) && $onehot0(Rout) && (Gin || operacao == 4'b0000))) begin
            bad++;
            $display("FAIL bus_invariant t=%0t: Rin=%b Rout=%b Gin=%b operacao=%b required one-hot/zero and operacao=0 outside T2",
                     $time, Rin, Rout, Gin, operacao);
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Run = 1'b1; DIN = 16'h5440;
        step();
        exp_v = ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL rst_hold1: got=%h exp=%h", obs, exp_v); end
        step();
        total++; if (obs !== exp_v) begin bad++; $display("FAIL rst_hold2: got=%h exp=%h", obs, exp_v); end
        Reset = 1'b0; Run = 1'b0;
        #1;
        total++; if (obs !== exp_v) begin bad++; $display("FAIL rst_release: got=%h exp=%h", obs, exp_v); end
        step();
        total++; if (obs !== exp_v) begin bad++; $display("FAIL rst_idle: got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_mvi();
        Run = 1'b1; DIN = 16'h1200;
        #1;
        exp_v = ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL mvi_t0: got=%h exp=%h", obs, exp_v); end
        step();
        Run = 1'b0; DIN = 16'h00AB;
        #1;
        exp_v = ex(0, 8'h02, 8'h00, 0, 0, 0, 1, 4'h0, 1);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL mvi_t1: got=%h exp=%h", obs, exp_v); end
        step();
        exp_v = ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL mvi_back_t0: got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_add();
        Run = 1'b1; DIN = 16'h5440;
        step();
        Run = 1'b0; DIN = 16'hFFFF;
        #1;
        exp_v = ex(0, 8'h00, 8'h04, 1, 0, 0, 0, 4'h0, 0);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL add_t1: got=%h exp=%h", obs, exp_v); end
        step();
        exp_v = ex(0, 8'h00, 8'h02, 0, 1, 0, 0, 4'b0101, 0);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL add_t2: got=%h exp=%h", obs, exp_v); end
        step();
        exp_v = ex(0, 8'h04, 8'h00, 0, 0, 1, 0, 4'h0, 1);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL add_t3_done: got=%h exp=%h", obs, exp_v); end
        step();
        exp_v = ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL add_back_t0: got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_mvnz();
        G_nz = 1'b0; Run = 1'b1; DIN = 16'h2C40;
        step();
        Run = 1'b0;
        #1;
        exp_v = ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 1);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL mvnz_gz0: got=%h exp=%h", obs, exp_v); end
        step();
        G_nz = 1'b1; Run = 1'b1;
        step();
        Run = 1'b0;
        #1;
        exp_v = ex(0, 8'h40, 8'h02, 0, 0, 0, 0, 4'h0, 1);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL mvnz_gz1: got=%h exp=%h", obs, exp_v); end
        step();
        G_nz = 1'b0;
    endtask

    task automatic test_back_to_back();
        Run = 1'b1; DIN = 16'h6440;
        step();
        DIN = 16'h0000;
        #1;
        exp_v = ex(0, 8'h00, 8'h04, 1, 0, 0, 0, 4'h0, 0);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL b2b_sub_t1: got=%h exp=%h", obs, exp_v); end
        step();
        Run = 1'b0;
        #1;
        exp_v = ex(0, 8'h00, 8'h02, 0, 1, 0, 0, 4'b0110, 0);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL b2b_sub_t2: got=%h exp=%h", obs, exp_v); end
        step();
        Run = 1'b1; DIN = 16'h1E00;
        #1;
        exp_v = ex(0, 8'h04, 8'h00, 0, 0, 1, 0, 4'h0, 1);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL b2b_sub_t3: got=%h exp=%h", obs, exp_v); end
        step();
        DIN = 16'hA440;
        #1;
        exp_v = ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL b2b_gap_t0: got=%h exp=%h", obs, exp_v); end
        step();
        exp_v = ex(0, 8'h00, 8'h04, 1, 0, 0, 0, 4'h0, 0);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL b2b_sll_t1: got=%h exp=%h", obs, exp_v); end
        step();
        exp_v = ex(0, 8'h00, 8'h02, 0, 1, 0, 0, 4'b1010, 0);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL b2b_sll_t2: got=%h exp=%h", obs, exp_v); end
        step();
        Run = 1'b0;
        #1;
        exp_v = ex(0, 8'h04, 8'h00, 0, 0, 1, 0, 4'h0, 1);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL b2b_sll_t3: got=%h exp=%h", obs, exp_v); end
        step();
    endtask

    task automatic test_illegal();
        Run = 1'b1; DIN = 16'hF000;
        step();
        Run = 1'b0;
        #1;
        exp_v = ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 1);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL illegal_t1: got=%h exp=%h", obs, exp_v); end
        step();
        exp_v = ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL illegal_back_t0: got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_reset_abort();
        Run = 1'b1; DIN = 16'h7440;
        step();
        Run = 1'b0;
        step();
        exp_v = ex(0, 8'h00, 8'h02, 0, 1, 0, 0, 4'b0111, 0);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL abort_or_t2: got=%h exp=%h", obs, exp_v); end
        Reset = 1'b1;
        #1;
        exp_v = ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 4'h0, 0);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL abort_rst_cycle: got=%h exp=%h", obs, exp_v); end
        step();
        Reset = 1'b0;
        #1;
        total++; if (obs !== exp_v) begin bad++; $display("FAIL abort_after1: got=%h exp=%h", obs, exp_v); end
        step();
        total++; if (obs !== exp_v) begin bad++; $display("FAIL abort_after2: got=%h exp=%h", obs, exp_v); end
    endtask

    initial begin
        test_reset();
        test_mvi();
        test_add();
        test_mvnz();
        test_back_to_back();
        test_illegal();
        test_reset_abort();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
